mtp_checker: RTL

- Stimulus generator and response checker for the two-input, one-output logic circuits built in this codebase (`mtpx`, `mtpy` in; `mtpz` out).
- It drives all four input combinations into the circuit under test, waits a programmable settle time, samples `mtpz` and compares it against an expected truth table.
- It accumulates mismatch statistics and reports pass/fail through a start/busy/done handshake.
- It sits beside the circuit under test in the simulation and self-test harnesses.

---
 rtl/mtp_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mtp_checker.sv
// Exhaustive stimulus generator and response checker for a two-input, one-output circuit.
// Sweeps {mtpx,mtpy} through 00..11, samples mtpz after a settle delay and tallies mismatches.
module mtp_checker #(
  parameter logic [3:0]  EXPECTED = 4'b1000,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned PASSES   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mtpx,
  output logic             mtpy,
  input  logic             mtpz,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0]       SETTLE_V = 8'(SETTLE);
  localparam logic [7:0]       PASSES_V = 8'(PASSES);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [1:0]       idx_r;
  logic [7:0]       settle_r;
  logic [7:0]       pass_cnt_r;
  logic             mismatch_s;
  logic [CNT_W-1:0] err_next_s;

  assign mismatch_s = mtpz ^ EXPECTED[idx_r];

  // Saturating next value of the mismatch counter for the current sample.
  always_comb begin
    err_next_s = err_count;
    if (mismatch_s && (err_count != ERR_MAX)) begin
      err_next_s = err_count + ERR_ONE;
    end else begin
      err_next_s = err_count;
    end
  end

  // Sweep sequencer with registered outputs; reset wins over any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= 2'd0;
      settle_r   <= 8'd0;
      pass_cnt_r <= 8'd0;
      mtpx       <= 1'b0;
      mtpy       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= {CNT_W{1'b0}};
      fail_vec   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= DRIVE;
            busy       <= 1'b1;
            err_count  <= {CNT_W{1'b0}};
            fail_vec   <= 4'd0;
            pass       <= 1'b0;
            idx_r      <= 2'd0;
            pass_cnt_r <= 8'd0;
          end
        end
        DRIVE: begin
          mtpx <= idx_r[1];
          mtpy <= idx_r[0];
          if (SETTLE_V == 8'd0) begin
            state_r <= SAMPLE;
          end else begin
            settle_r <= SETTLE_V - 8'd1;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (settle_r == 8'd0) begin
            state_r <= SAMPLE;
          end else begin
            settle_r <= settle_r - 8'd1;
          end
        end
        SAMPLE: begin
          err_count <= err_next_s;
          if (mismatch_s) begin
            fail_vec[idx_r] <= 1'b1;
          end
          if (idx_r != 2'd3) begin
            idx_r   <= idx_r + 2'd1;
            state_r <= DRIVE;
          end else begin
            idx_r      <= 2'd0;
            pass_cnt_r <= pass_cnt_r + 8'd1;
            // The verdict includes this final sample so it is valid alongside done.
            if ((pass_cnt_r + 8'd1) == PASSES_V) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next_s == {CNT_W{1'b0}});
            end else begin
              state_r <= DRIVE;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
